// File: rtl/pe_stream_tx.sv
// Global-buffer to PE stream transmitter: one start_load pulse, then
// `length` SRAM words streamed into the PE FIFO under backpressure.
module pe_stream_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  fifo_full,
  output logic                  start_load,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_en,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    STREAM,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued;
  logic [LEN_WIDTH-1:0]  popped;
  logic                  inflight;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic [DATA_WIDTH-1:0] fifo_mem [2];

  logic       active;
  logic       pop;
  logic       issue;
  logic       last_pop;
  logic [2:0] occ;

  assign active   = (state == START) || (state == STREAM);
  assign occ      = {1'b0, count} + {2'b00, inflight};
  assign pop      = (count != 2'd0) && !fifo_full;
  // Reserve a slot for every read in flight so the buffer cannot overflow.
  assign issue    = active && (issued < len_q) &&
                    ((occ <= 3'd1) || pop);
  assign last_pop = pop && (popped == len_q - 1'b1);

  assign mem_rd_en   = issue;
  assign mem_addr    = rd_addr;
  assign data_out    = fifo_mem[rd_ptr];
  assign data_out_en = pop;
  assign start_load  = (state == START);
  assign busy        = active;
  assign done        = (state == DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = (length == '0) ? DONE : START;
        end
      end
      START:  state_nx = STREAM;
      STREAM: begin
        if (last_pop) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd_addr     <= '0;
      len_q       <= '0;
      issued      <= '0;
      popped      <= '0;
      inflight    <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      state    <= state_nx;
      inflight <= issue;
      count    <= count + {1'b0, inflight} - {1'b0, pop};
      if (state == IDLE && start) begin
        rd_addr <= base_addr;
        len_q   <= length;
        issued  <= '0;
        popped  <= '0;
      end
      if (issue) begin
        rd_addr <= rd_addr + 1'b1;
        issued  <= issued + 1'b1;
      end
      // SRAM data lands one cycle after its strobe.
      if (inflight) begin
        fifo_mem[wr_ptr] <= mem_rd_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        popped <= popped + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pe_stream_tx.sv
// Scoreboard bench for pe_stream_tx with an SRAM model mem[a] = a + 1.
module tb_pe_stream_tx;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic [7:0]  length;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rd_data;
  logic        fifo_full;
  logic        start_load;
  logic [15:0] data_out;
  logic        data_out_en;
  logic        busy;
  logic        done;

  pe_stream_tx #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(8),
    .LEN_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .fifo_full  (fifo_full),
    .start_load (start_load),
    .data_out   (data_out),
    .data_out_en(data_out_en),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM: data valid one cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= {8'h00, mem_addr} + 16'd1;
    else           mem_rd_data <= 16'hdead;
  end

  int checks = 0;
  int errors = 0;

  logic [15:0] q [$];
  logic [7:0]  addrs [$];

  int sl_cnt, sl_first, rd_cnt, rd_by10;
  int en_cnt, first_en, last_en, en_win, first_after;
  int done_cnt, done_cyc;
  logic busy_pre, busy_at_done, prev_busy;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic run(input logic [7:0] base, input logic [7:0] len,
                     input int ff_lo, input int ff_hi,
                     input int restart_at, input int rst_at);
    logic [7:0] a;
    sl_cnt = 0; sl_first = -1; rd_cnt = 0; rd_by10 = 0;
    en_cnt = 0; first_en = -1; last_en = -1; en_win = 0;
    first_after = -1; done_cnt = 0; done_cyc = -1;
    busy_pre = 1'b0; busy_at_done = 1'b0; prev_busy = 1'b0;
    addrs.delete();
    for (int i = 0; i < int'(len); i++) begin
      a = base + 8'(i);
      q.push_back({8'h00, a} + 16'd1);
    end
    @(negedge clk);
    base_addr = base;
    length    = len;
    start     = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 300; k++) begin
      #1;
      fifo_full = (k >= ff_lo) && (k <= ff_hi);
      start     = (k == restart_at);
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_ctl", {27'd0, start_load, mem_rd_en, data_out_en,
                        busy, done}, 32'd0);
        chk("rst_dat", {8'd0, mem_addr, data_out}, 32'd0);
        q.delete();
      end
      @(negedge clk);
      if (start_load) begin
        sl_cnt++;
        if (sl_first < 0) sl_first = k;
      end
      if (mem_rd_en) begin
        rd_cnt++;
        if (k <= 10) rd_by10++;
        addrs.push_back(mem_addr);
      end
      if (data_out_en) begin
        en_cnt++;
        if (first_en < 0) first_en = k;
        last_en = k;
        if (k >= ff_lo && k <= ff_hi) en_win++;
        if (k > ff_hi && first_after < 0) first_after = k;
        if (q.size() == 0) chk("extra_word", 32'd1, 32'd0);
        else chk("data", {16'd0, data_out}, {16'd0, q.pop_front()});
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc     = k;
          busy_pre     = prev_busy;
          busy_at_done = busy;
        end
      end
      prev_busy = busy;
      if (rst_at > 0 && k >= rst_at + 3) break;
      if (done_cyc >= 0 && k >= done_cyc + 3) break;
      @(posedge clk);
    end
    fifo_full = 1'b0;
    start     = 1'b0;
    if (rst_at > 0) rst_n = 1'b1;
    else chk("done_timeout", {31'd0, done_cyc >= 0}, 32'd1);
    chk("leftover", q.size(), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0;
    length = '0; fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", {27'd0, start_load, mem_rd_en, data_out_en,
                      busy, done}, 32'd0);
    chk("reset_dat", {8'd0, mem_addr, data_out}, 32'd0);
    rst_n = 1'b1;

    run(8'd0, 8'd6, 0, 0, 0, 0);
    chk("t1_sl_cnt", sl_cnt, 1);
    chk("t1_sl_cyc", sl_first, 1);
    chk("t1_first_en", first_en, 3);
    chk("t1_last_en", last_en, 8);
    chk("t1_words", en_cnt, 6);
    chk("t1_rds", rd_cnt, 6);
    chk("t1_done_cyc", done_cyc, 9);
    chk("t1_busy_pre", {31'd0, busy_pre}, 32'd1);
    chk("t1_busy_done", {31'd0, busy_at_done}, 32'd0);

    run(8'd0, 8'd9, 4, 10, 0, 0);
    chk("t2_en_win", en_win, 0);
    chk("t2_rd_by10", rd_by10, 3);
    chk("t2_resume", first_after, 11);
    chk("t2_words", en_cnt, 9);
    chk("t2_rds", rd_cnt, 9);
    chk("t2_done", done_cnt, 1);

    run(8'd254, 8'd4, 0, 0, 0, 0);
    chk("t3_rds", addrs.size(), 4);
    if (addrs.size() == 4) begin
      chk("t3_a0", addrs[0], 254);
      chk("t3_a1", addrs[1], 255);
      chk("t3_a2", addrs[2], 0);
      chk("t3_a3", addrs[3], 1);
    end
    chk("t3_words", en_cnt, 4);

    run(8'd10, 8'd0, 0, 0, 0, 0);
    chk("t4_done_cyc", done_cyc, 1);
    chk("t4_sl", sl_cnt, 0);
    chk("t4_rds", rd_cnt, 0);
    chk("t4_words", en_cnt, 0);

    run(8'd20, 8'd6, 0, 0, 4, 0);
    chk("t5_words", en_cnt, 6);
    chk("t5_done", done_cnt, 1);
    chk("t5_sl", sl_cnt, 1);

    run(8'd40, 8'd12, 0, 0, 0, 5);
    chk("t6_no_done", done_cnt, 0);
    chk("t6_pre_words", en_cnt, 2);

    run(8'd100, 8'd3, 0, 0, 0, 0);
    chk("t7_words", en_cnt, 3);
    chk("t7_done_cyc", done_cyc, 6);
    chk("t7_a0", addrs.size() > 0 ? {24'd0, addrs[0]} : 32'hffff, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
